img_ram_32x32: RTL and testbench

Sprite memory for the 32x32 sprite-drawing stage of the video pipeline. It answers the drawing stage's 10-bit `pixel_addr` with the 12-bit `rgb_pixel` one clock later. It is also loaded at run time from a byte-serial source over a valid/ready handshake, with two 12-bit pixels packed into three bytes. Sprite art (car, obstacles) can therefore be swapped without re-synthesis.

---
 rtl/img_ram_32x32.sv | 79 +++++++
 tb/tb_img_ram_32x32.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/img_ram_32x32.sv
// img_ram_32x32: 1024x12 sprite RAM with a registered read port and a byte-serial 3-bytes-per-2-pixels loader; `IMG_RAM_MIRROR_EN` enables horizontal flip on reads
module img_ram_32x32 #(
  parameter int PIXELS = 1024
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [9:0]  pixel_addr,
  output logic [11:0] rgb_pixel,
  input  logic        mirror,
  input  logic        load_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;
  localparam logic [9:0] last_addr = 10'(PIXELS - 1);
  logic [11:0] mem [PIXELS];
  state_t      state, state_next;
  logic [9:0]  wa, raddr;
  logic [7:0]  hold;
  logic [3:0]  nib;
  logic        accept, we, last;
  logic [11:0] wdata;
`ifdef IMG_RAM_MIRROR_EN
  assign raddr = {pixel_addr[9:5], pixel_addr[4:0] ^ {5{mirror}}};
`else
  logic unused_mirror;
  assign raddr = pixel_addr;
  assign unused_mirror = mirror;
`endif
  // handshake, write strobe and next-state decode
  always_comb begin
    busy       = state != IDLE;
    in_ready   = busy;
    accept     = in_valid && in_ready;
    we         = accept && (state == B1 || state == B2);
    wdata      = state == B1 ? {hold, in_data[7:4]} : {nib, in_data};
    last       = accept && state == B2 && wa == last_addr;
    state_next = state == IDLE ? (load_start ? B0 : IDLE) :
                 !accept       ? state :
                 state == B0   ? B1 :
                 state == B1   ? B2 :
                 last          ? IDLE : B0;
  end
  // load state register
  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end
  // write pointer, byte unpacking registers and completion pulse
  always_ff @(posedge pclk) begin
    if (rst) begin
      wa   <= '0;
      hold <= '0;
      nib  <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (state == IDLE && load_start) wa <= '0;
      if (accept && state == B0) hold <= in_data;
      if (accept && state == B1) begin
        nib <= in_data[3:0];
        wa  <= wa + 10'd1;
      end
      if (accept && state == B2 && !last) wa <= wa + 10'd1;
    end
  end
  // write port; contents deliberately survive reset
  always_ff @(posedge pclk) begin
    if (we) mem[wa] <= wdata;
  end
  // registered read port, read-before-write on address collision
  always_ff @(posedge pclk) begin
    if (rst) rgb_pixel <= '0;
    else     rgb_pixel <= mem[raddr];
  end
endmodule

// File: tb/tb_img_ram_32x32.sv
// tb_img_ram_32x32: directed scoreboard bench for the sprite RAM loader and read port
module tb_img_ram_32x32;
  logic        pclk = 0, rst = 1, mirror = 0, load_start = 0, in_valid = 0;
  logic [9:0]  pixel_addr = '0;
  logic [7:0]  in_data = '0;
  logic [11:0] rgb_pixel;
  logic        in_ready, busy, done;
  int          checks = 0, failures = 0;
  logic [11:0] model [1024];
  logic [11:0] pix_new [1024];
  logic [11:0] q [$];

  img_ram_32x32 dut (
    .pclk(pclk), .rst(rst), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .mirror(mirror), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int i);
    logic [11:0] p0, p1;
    int r;
    p0 = pix_new[i / 3 * 2];
    p1 = pix_new[i / 3 * 2 + 1];
    r  = i % 3;
    return r == 0 ? p0[11:4] : r == 1 ? {p0[3:0], p1[11:8]} : p1[7:0];
  endfunction

  task automatic read_all();
    for (int a = 0; a < 1024; a++) begin
      pixel_addr = 10'(a);
      q.push_back(model[a]);
      step();
      check($sformatf("rd[%0d]", a), 32'(rgb_pixel), 32'(q.pop_front()));
    end
  endtask

  task automatic run_load(input bit stall, input int restart_at, input int abort_at, input bit probe);
    int i, pi, dones, cyc;
    load_start = 1;
    step();
    load_start = 0;
    check("busy_rise", 32'(busy), 1);
    check("ready_rise", 32'(in_ready), 1);
    i = 0; dones = 0; cyc = 0;
    while (i < 1536 && cyc < 20000 && i != abort_at) begin
      pi = i;
      in_valid   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data    = byte_of(i);
      load_start = i == restart_at;
      if (probe && (pi == 8 || pi == 9)) begin
        pixel_addr = 10'd5;
        q.push_back(pi == 8 ? model[5] : pix_new[5]);
      end
      step();
      cyc++;
      if (probe && (pi == 8 || pi == 9)) check(pi == 8 ? "rw_old" : "rw_new", 32'(rgb_pixel), 32'(q.pop_front()));
      if (in_valid) i++;
      if (done) dones++;
    end
    in_valid = 0;
    load_start = 0;
    if (abort_at >= 0) begin
      check("busy_before_rst", 32'(busy), 1);
      rst = 1;
      step();
      rst = 0;
      check("abort_busy", 32'(busy), 0);
      check("abort_ready", 32'(in_ready), 0);
      for (int k = 0; k < abort_at / 3 * 2; k++) model[k] = pix_new[k];
      in_valid = 1;
      step();
      check("abort_idle_ready", 32'(in_ready), 0);
      in_valid = 0;
    end else begin
      check("accepts", 32'(i), 1536);
      check("done_pulse", 32'(done), 1);
      check("done_busy", 32'(busy), 0);
      check("done_ready", 32'(in_ready), 0);
      step();
      check("done_drop", 32'(done), 0);
      check("done_count", 32'(dones), 1);
      for (int k = 0; k < 1024; k++) model[k] = pix_new[k];
    end
  endtask

  initial begin
    in_valid = 1;
    step();
    step();
    check("rst_rgb", 32'(rgb_pixel), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("idle_ready", 32'(in_ready), 0);
    end
    in_valid = 0;
    for (int k = 0; k < 1024; k++) pix_new[k] = 12'($urandom);
    pix_new[0] = 12'hABC; pix_new[1] = 12'hDEF; pix_new[2] = 12'h123; pix_new[3] = 12'h456;
    run_load(0, -1, -1, 0);
    for (int a = 0; a < 4; a++) begin
      pixel_addr = 10'(a);
      q.push_back(a == 0 ? 12'hABC : a == 1 ? 12'hDEF : a == 2 ? 12'h123 : 12'h456);
      step();
      check($sformatf("first4[%0d]", a), 32'(rgb_pixel), 32'(q.pop_front()));
    end
    read_all();
    for (int k = 0; k < 1024; k++) pix_new[k] = 12'($urandom);
    run_load(1, -1, -1, 0);
    read_all();
    for (int k = 0; k < 1024; k++) pix_new[k] = 12'($urandom);
    run_load(0, 700, 900, 0);
    read_all();
    for (int k = 0; k < 1024; k++) pix_new[k] = 12'($urandom);
    pix_new[5] = ~model[5];
    run_load(0, -1, -1, 1);
    read_all();
    for (int k = 0; k < 1024; k++) pix_new[k] = 12'(k);
    run_load(0, -1, -1, 0);
    mirror = 1;
    pixel_addr = 10'h021;
`ifdef IMG_RAM_MIRROR_EN
    q.push_back(12'h03E);
`else
    q.push_back(12'h021);
`endif
    step();
    check("mirror_on", 32'(rgb_pixel), 32'(q.pop_front()));
    mirror = 0;
    q.push_back(12'h021);
    step();
    check("mirror_off", 32'(rgb_pixel), 32'(q.pop_front()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
